// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding
// and the default operand width.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_W = 8;

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle of the multiplier. The requester drives start and
// operands; the multiplier returns product, busy and done.
interface seq_shift_add_multiplier_if
  import seq_mul_pkg::*;
#(
  parameter int N = MUL_W
);

  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, done
  );

endinterface

// File: rtl/nbitshiftleft.sv
// N-bit logical shift left by one position, zero filled.
module nbitshiftleft #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = {a[N-2:0], 1'b0};

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned N x N multiplier: one partial product per cycle over N RUN cycles,
// followed by a single DONE cycle that presents the new product.
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int N = MUL_W
) (
  input logic                     clk,
  input logic                     rst,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int CW = $clog2(N);

  state_t         state_reg, state_next;
  logic [2*N-1:0] mcand_reg;
  logic [2*N-1:0] mcand_shl;
  logic [2*N-1:0] acc_reg;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] product_reg;
  logic [N-1:0]   mplier_reg;
  logic [CW-1:0]  cnt_reg;
  logic           last_step;

  nbitshiftleft #(.N(2 * N)) u_mcand_shl (
    .a (mcand_reg),
    .y (mcand_shl)
  );

  assign last_step = (cnt_reg == CW'(N - 1));
  assign acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mcand_reg  <= {{N{1'b0}}, bus.multiplicand};
            mplier_reg <= bus.multiplier;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_shl;
          mplier_reg <= mplier_reg >> 1;
          // Counter stops at N-1 so it never wraps for power-of-two N.
          if (last_step) begin
            product_reg <= acc_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = (state_reg == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier at N=8 and N=16 with
// hand-computed products and cycle-exact latency checks.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.N(8))  b8 ();
  seq_shift_add_multiplier_if #(.N(16)) b16 ();

  seq_shift_add_multiplier #(.N(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  seq_shift_add_multiplier #(.N(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  function automatic logic busy_of(input bit wide);
    return wide ? b16.busy : b8.busy;
  endfunction

  function automatic logic done_of(input bit wide);
    return wide ? b16.done : b8.done;
  endfunction

  function automatic logic [31:0] prod_of(input bit wide);
    return wide ? b16.product : {16'h0, b8.product};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; returns 1 ns after the accepting edge.
  task automatic launch(input bit wide, input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      b16.start = 1'b1; b16.multiplicand = a; b16.multiplier = b;
    end else begin
      b8.start = 1'b1; b8.multiplicand = a[7:0]; b8.multiplier = b[7:0];
    end
    tick();
    b8.start  = 1'b0;
    b16.start = 1'b0;
  endtask

  // Samples each cycle while busy (bounded); leaves us in the first idle cycle.
  task automatic wait_op(input bit wide, output int busy_n, output int done_n,
                         output int done_at, output logic [31:0] prod);
    busy_n = 0; done_n = 0; done_at = 0; prod = '0;
    for (int i = 1; i <= 40; i++) begin
      if (!busy_of(wide)) break;
      busy_n++;
      if (done_of(wide)) begin
        done_n++;
        done_at = i;
        prod    = prod_of(wide);
      end
      tick();
    end
  endtask

  task automatic do_op(input string tag, input bit wide, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    int busy_n, done_n, done_at, lat;
    logic [31:0] prod;
    lat = wide ? 17 : 9;
    launch(wide, a, b);
    wait_op(wide, busy_n, done_n, done_at, prod);
    check({tag, "_prod"},   prod, exp);
    check({tag, "_busy_n"}, busy_n, lat);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_done_at"}, done_at, lat);
    check({tag, "_hold"},   prod_of(wide), exp);
  endtask

  initial begin
    int busy_n, done_n, done_at, extra;
    logic [31:0] prod;

    b8.start = 1'b0;  b8.multiplicand = '0;  b8.multiplier = '0;
    b16.start = 1'b0; b16.multiplicand = '0; b16.multiplier = '0;
    rst = 1'b1;
    repeat (2) tick();
    check("rst_busy", b8.busy, 1'b0);
    check("rst_done", b8.done, 1'b0);
    check("rst_prod", b8.product, 16'h0);
    check("rst_prod16", b16.product, 32'h0);
    rst = 1'b0;
    tick();

    do_op("m13x11", 1'b0, 16'd13, 16'd11, 32'd143);

    do_op("m255x255", 1'b0, 16'd255, 16'd255, 32'hFE01);
    extra = 0;
    repeat (4) begin
      if (b8.done) extra++;
      tick();
    end
    check("m255_no_spur", extra, 0);

    do_op("m0x200", 1'b0, 16'd0, 16'd200, 32'd0);
    do_op("m77x0",  1'b0, 16'd77, 16'd0, 32'd0);
    do_op("m1x1",   1'b0, 16'd1, 16'd1, 32'd1);
    do_op("m128x2", 1'b0, 16'd128, 16'd2, 32'd256);

    // start held high, operands swapped mid-RUN, back-to-back restart
    b8.start = 1'b1; b8.multiplicand = 8'd6; b8.multiplier = 8'd7;
    tick();
    repeat (3) tick();
    b8.multiplicand = 8'd9; b8.multiplier = 8'd3;
    wait_op(1'b0, busy_n, done_n, done_at, prod);
    check("hold_prod",   prod, 32'd42);
    check("hold_busy_n", busy_n, 6);
    check("hold_done_n", done_n, 1);
    check("hold_idle",   b8.busy, 1'b0);
    tick();
    check("b2b_busy", b8.busy, 1'b1);
    b8.start = 1'b0;
    wait_op(1'b0, busy_n, done_n, done_at, prod);
    check("b2b_prod",   prod, 32'd27);
    check("b2b_busy_n", busy_n, 9);

    // reset during the 4th RUN cycle aborts with no done pulse
    launch(1'b0, 16'd13, 16'd11);
    repeat (3) tick();
    check("abort_inrun", b8.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", b8.busy, 1'b0);
    check("abort_done", b8.done, 1'b0);
    check("abort_prod", b8.product, 16'h0);
    extra = 0;
    repeat (12) begin
      if (b8.done) extra++;
      tick();
    end
    check("abort_no_done", extra, 0);

    do_op("after_rst", 1'b0, 16'd3, 16'd5, 32'd15);

    do_op("w16", 1'b1, 16'hFFFF, 16'h0002, 32'h1FFFE);
    do_op("w16max", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
